record_unit_param: RTL and testbench

Parametrised successor to the keypad record unit. It samples a key code every clock and measures how long each key is held, in prescaled ticks. When the key is released or changed, it emits one packed record {key, duration} to the record RAM write port at an auto-incrementing address. Over the previous generation it adds configurable widths, a duration prescaler, saturating duration, Full/Overflow status, a wrap mode and a synchronous Clear.

---
 rtl/record_unit_param.sv | 151 +++++++++++++++
 tb/tb_record_unit_param.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/record_unit_param.sv
// record_unit_param: keypad hold-time recorder emitting {key,dur} records
// to a RAM write port at an auto-incrementing address.
// Ports: RCLK, RRSTn (async low), Key, RecordEn, Clear in;
//   WriteEn, Address, Signal, Full, Overflow, Wrapped out (all registered).
// Optional: define REST_RECORD_EN to also record silence as {0,dur}.
module record_unit_param #(
   parameter int KEY_W    = 8,
   parameter int CNT_W    = 4,
   parameter int ADDR_W   = 11,
   parameter int TICK_DIV = 1,
   parameter int WRAP     = 0
) (
   input  logic                    RCLK,
   input  logic                    RRSTn,
   input  logic [KEY_W-1:0]        Key,
   input  logic                    RecordEn,
   input  logic                    Clear,
   output logic                    WriteEn,
   output logic [ADDR_W-1:0]       Address,
   output logic [KEY_W+CNT_W-1:0]  Signal,
   output logic                    Full,
   output logic                    Overflow,
   output logic                    Wrapped
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0]    TLAST = TW'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] DMAX  = '1;
   localparam logic [ADDR_W:0]  DEPTH = {1'b1, {ADDR_W{1'b0}}};
   localparam logic             CIRC  = (WRAP != 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      EMIT = 2'd2,
      REST = 2'd3
   } state_t;

   state_t            state;
   logic [KEY_W-1:0]  cur;
   logic [KEY_W-1:0]  nxt;
   logic [CNT_W-1:0]  dur;
   logic [TW-1:0]     tick;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W:0]   fill;

   logic              tick_done;
   logic [TW-1:0]     tick_nx;
   logic [CNT_W-1:0]  dur_nx;
   logic              do_wr;

   // Shared prescaler/saturating counter step for HOLD and REST.
   assign tick_done = (tick == TLAST);
   assign tick_nx   = tick_done ? '0 : tick + 1'b1;
   assign dur_nx    = (tick_done && dur != DMAX) ? dur + 1'b1 : dur;
   assign do_wr     = RecordEn && (CIRC || !Full);

   always_ff @(posedge RCLK or negedge RRSTn) begin
      if (!RRSTn) begin
         state    <= IDLE;
         cur      <= '0;
         nxt      <= '0;
         dur      <= '0;
         tick     <= '0;
         ptr      <= '0;
         fill     <= '0;
         WriteEn  <= 1'b0;
         Address  <= '0;
         Signal   <= '0;
         Full     <= 1'b0;
         Overflow <= 1'b0;
         Wrapped  <= 1'b0;
      end else if (Clear) begin
         state    <= IDLE;
         dur      <= '0;
         tick     <= '0;
         ptr      <= '0;
         fill     <= '0;
         WriteEn  <= 1'b0;
         Full     <= 1'b0;
         Overflow <= 1'b0;
         Wrapped  <= 1'b0;
      end else begin
         WriteEn <= 1'b0;
         unique case (state)
            IDLE: begin
               if (Key != '0) begin
                  cur   <= Key;
                  dur   <= '0;
                  tick  <= '0;
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (Key == cur) begin
                  tick <= tick_nx;
                  dur  <= dur_nx;
               end else begin
                  nxt   <= Key;
                  state <= EMIT;
               end
            end
            EMIT: begin
               if (do_wr) begin
                  WriteEn <= 1'b1;
                  Signal  <= {cur, dur};
                  Address <= ptr;
                  ptr     <= ptr + 1'b1;
                  if (!CIRC) begin
                     fill <= fill + 1'b1;
                     if (fill + 1'b1 == DEPTH) Full <= 1'b1;
                  end else if (ptr == '1) begin
                     Wrapped <= 1'b1;
                  end
               end else if (RecordEn) begin
                  Overflow <= 1'b1;
               end
               dur  <= '0;
               tick <= '0;
               if (nxt != '0) begin
                  cur   <= nxt;
                  state <= HOLD;
               end else begin
`ifdef REST_RECORD_EN
                  // A silence record is a key record with code 0.
                  cur   <= '0;
                  state <= REST;
`else
                  state <= IDLE;
`endif
               end
            end
            REST: begin
`ifdef REST_RECORD_EN
               if (Key == '0) begin
                  tick <= tick_nx;
                  dur  <= dur_nx;
               end else begin
                  nxt   <= Key;
                  state <= EMIT;
               end
`else
               state <= IDLE;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_record_unit_param.sv
// Directed bench for record_unit_param: four instances (default,
// prescaled, small stop-at-full, small circular) share one stimulus.
module tb_record_unit_param;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] key;
   logic       rec_en;
   logic       clr;

   int n_assert = 0;
   int n_fail   = 0;

   logic        we_a, full_a, ovf_a, wrp_a;
   logic [10:0] adr_a;
   logic [11:0] sig_a;
   logic        we_t, full_t, ovf_t, wrp_t;
   logic [10:0] adr_t;
   logic [11:0] sig_t;
   logic        we_f, full_f, ovf_f, wrp_f;
   logic [1:0]  adr_f;
   logic [11:0] sig_f;
   logic        we_w, full_w, ovf_w, wrp_w;
   logic [1:0]  adr_w;
   logic [11:0] sig_w;

   logic [31:0] qa[$];
   logic [31:0] qt[$];
   logic [31:0] qf[$];
   logic [31:0] qw[$];

   always #5 clk = ~clk;

   record_unit_param u_a (
      .RCLK(clk), .RRSTn(rst_n), .Key(key), .RecordEn(rec_en),
      .Clear(clr), .WriteEn(we_a), .Address(adr_a), .Signal(sig_a),
      .Full(full_a), .Overflow(ovf_a), .Wrapped(wrp_a));

   record_unit_param #(.TICK_DIV(4)) u_t (
      .RCLK(clk), .RRSTn(rst_n), .Key(key), .RecordEn(rec_en),
      .Clear(clr), .WriteEn(we_t), .Address(adr_t), .Signal(sig_t),
      .Full(full_t), .Overflow(ovf_t), .Wrapped(wrp_t));

   record_unit_param #(.ADDR_W(2), .WRAP(0)) u_f (
      .RCLK(clk), .RRSTn(rst_n), .Key(key), .RecordEn(rec_en),
      .Clear(clr), .WriteEn(we_f), .Address(adr_f), .Signal(sig_f),
      .Full(full_f), .Overflow(ovf_f), .Wrapped(wrp_f));

   record_unit_param #(.ADDR_W(2), .WRAP(1)) u_w (
      .RCLK(clk), .RRSTn(rst_n), .Key(key), .RecordEn(rec_en),
      .Clear(clr), .WriteEn(we_w), .Address(adr_w), .Signal(sig_w),
      .Full(full_w), .Overflow(ovf_w), .Wrapped(wrp_w));

   // Log every write strobe as {address, record}.
   always @(negedge clk) begin
      if (we_a) qa.push_back({16'(adr_a), 16'(sig_a)});
      if (we_t) qt.push_back({16'(adr_t), 16'(sig_t)});
      if (we_f) qf.push_back({16'(adr_f), 16'(sig_f)});
      if (we_w) qw.push_back({16'(adr_w), 16'(sig_w)});
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input logic [7:0] k, input int n);
      key = k;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n  = 1'b0;
      key    = 8'h00;
      rec_en = 1'b1;
      clr    = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_we",   32'(we_a),   32'd0);
      chk("rst_addr", 32'(adr_a),  32'd0);
      chk("rst_sig",  32'(sig_a),  32'd0);
      chk("rst_full", 32'(full_f), 32'd0);
      chk("rst_ovf",  32'(ovf_f),  32'd0);
      chk("rst_wrp",  32'(wrp_w),  32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 0x41 sampled on 5 edges -> dur 4
      hold(8'h41, 5);
      hold(8'h00, 4);
      chk("basic_cnt", 32'(qa.size()), 32'd1);
      chk("basic_rec", qa[0], {16'd0, 16'h414});
      chk("hold_sig",  32'(sig_a), 32'h414);
      chk("hold_adr",  32'(adr_a), 32'd0);
      chk("hold_we",   32'(we_a),  32'd0);
      chk("tdiv_short", qt[0], {16'd0, 16'h411});

      // 40 cycles saturates a 4-bit duration
      hold(8'h22, 40);
      hold(8'h00, 4);
      chk("sat_rec", qa[1], {16'd1, 16'h22F});

      // TICK_DIV=4, 9 held cycles -> dur 2
      hold(8'h55, 9);
      hold(8'h00, 4);
      chk("tdiv_rec", qt[2], {16'd2, 16'h552});

      // back-to-back keys; the EMIT cycle of 0x32 is not counted
      hold(8'h31, 3);
      hold(8'h32, 3);
      hold(8'h00, 4);
      chk("b2b_cnt",  32'(qa.size()), 32'd5);
      chk("b2b_rec0", qa[3], {16'd3, 16'h312});
      chk("b2b_rec1", qa[4], {16'd4, 16'h321});

      // ADDR_W=2 stop mode: 5th event dropped
      chk("full_cnt",  32'(qf.size()), 32'd4);
      chk("full_adr3", qf[3], {16'd3, 16'h312});
      chk("full_flag", 32'(full_f), 32'd1);
      chk("full_ovf",  32'(ovf_f),  32'd1);
      chk("full_adr",  32'(adr_f),  32'd3);

      // ADDR_W=2 circular mode: 5th event lands at 0
      chk("wrap_cnt",  32'(qw.size()), 32'd5);
      chk("wrap_rec",  qw[4], {16'd0, 16'h321});
      chk("wrap_flag", 32'(wrp_w),  32'd1);
      chk("wrap_full", 32'(full_w), 32'd0);

      // RecordEn=0: measured but discarded
      rec_en = 1'b0;
      hold(8'h66, 3);
      hold(8'h00, 4);
      rec_en = 1'b1;
      chk("noen_cnt", 32'(qw.size()), 32'd5);
      hold(8'h44, 2);
      hold(8'h00, 4);
      chk("noen_ptr", qw[5], {16'd1, 16'h441});
      chk("noen_a",   qa[5], {16'd5, 16'h441});
      chk("drop_cnt", 32'(qf.size()), 32'd4);

      // Clear restarts pointer and status
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_full", 32'(full_f), 32'd0);
      chk("clr_ovf",  32'(ovf_f),  32'd0);
      chk("clr_wrp",  32'(wrp_w),  32'd0);
      hold(8'h77, 2);
      hold(8'h00, 4);
      chk("clr_recf", qf[4], {16'd0, 16'h771});
      chk("clr_reca", qa[6], {16'd0, 16'h771});

      // Clear during EMIT suppresses the write
      hold(8'h99, 3);
      hold(8'h00, 1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      hold(8'h00, 4);
      chk("clr_emit", 32'(qa.size()), 32'd7);

      // async reset mid-HOLD
      hold(8'h88, 3);
      rst_n = 1'b0;
      #1;
      chk("arst_we",  32'(we_a),  32'd0);
      chk("arst_adr", 32'(adr_a), 32'd0);
      chk("arst_sig", 32'(sig_a), 32'd0);
      key = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      hold(8'h00, 4);
      chk("arst_cnt", 32'(qa.size()), 32'd7);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
